// File: rtl/xbf_pkg.sv
// ============================================================================
// xbf_pkg : shared constants, keep encodings and FSM states for the packer
// Revision: 1.0
// ============================================================================
`default_nettype none

package xbf_pkg;
  localparam int SUM_W    = 32;
  localparam int AXIS_W   = 128;
  localparam int KEEP_W   = AXIS_W / 8;
  localparam int ENTRY_W  = AXIS_W + KEEP_W + 1;

  localparam logic [KEEP_W-1:0] KEEP_FULL = 16'hFFFF;
  localparam logic [KEEP_W-1:0] KEEP_LOW  = 16'h00FF;
  localparam logic [KEEP_W-1:0] KEEP_NULL = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/xbf_sync_fifo.sv
// ============================================================================
// xbf_sync_fifo : single-clock first-word-fall-through FIFO with level output
// Revision: 1.0
// ============================================================================
`default_nettype none

module xbf_sync_fifo #(
  parameter int WIDTH = 145,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_level;
  logic             w_rd;
  logic             w_wr;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd];

  // A push into a full FIFO is legal when a pop frees the slot in the same cycle.
  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= i_wdata;
  end
endmodule

`default_nettype wire

// File: rtl/xbf_beam_packer.sv
// ============================================================================
// xbf_beam_packer : packs complex beam sums in pairs into framed 128-bit AXIS
// beats with start/stop flush control and sticky overflow status.
// Revision: 1.0
// ============================================================================
`default_nettype none

module xbf_beam_packer #(
  parameter int SUM_W      = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          enable,
  input  logic [CNT_W-1:0]              pkt_beats,
  input  logic                          sum_valid,
  input  logic [SUM_W-1:0]              sum_r,
  input  logic [SUM_W-1:0]              sum_i,
  output logic [127:0]                  m_axis_tdata,
  output logic [15:0]                   m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  import xbf_pkg::*;

  localparam int SAMPLE_W = 2 * SUM_W;

  state_t                r_state;
  logic                  r_half_vld;
  logic [SAMPLE_W-1:0]   r_half;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_pkt;
  logic                  r_ovf;

  logic [SAMPLE_W-1:0]   w_sample;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_last;
  logic                  w_pop;
  logic                  w_can_push;
  logic                  w_push;
  logic                  w_drop;
  logic [ENTRY_W-1:0]    w_entry;
  logic [ENTRY_W-1:0]    w_rdata;
  logic                  w_full;
  logic                  w_empty;

  assign w_sample   = {sum_i, sum_r};
  assign w_cnt_nxt  = r_cnt + 1'b1;
  assign w_last     = (r_pkt != '0) && (w_cnt_nxt == r_pkt);
  assign w_pop      = m_axis_tvalid && m_axis_tready;
  assign w_can_push = !w_full || w_pop;
  assign w_drop     = (r_state == ST_RUN) && sum_valid && r_half_vld && !w_can_push;

  // Entry layout: {tdata, tkeep, tlast}.
  always_comb begin
    w_push  = 1'b0;
    w_entry = '0;
    case (r_state)
      ST_RUN: begin
        if (sum_valid && r_half_vld) begin
          w_push  = w_can_push;
          w_entry = {w_sample, r_half, KEEP_FULL, w_last};
        end
      end
      ST_FLUSH: begin
        if (r_half_vld) begin
          w_push  = w_can_push;
          w_entry = {{SAMPLE_W{1'b0}}, r_half, KEEP_LOW, 1'b1};
        end else if (r_cnt != '0) begin
          w_push  = w_can_push;
          w_entry = {{AXIS_W{1'b0}}, KEEP_NULL, 1'b1};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_half_vld <= 1'b0;
      r_half     <= '0;
      r_cnt      <= '0;
      r_pkt      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        // Enable can only be high in IDLE if it rose since the last RUN ended.
        ST_IDLE: begin
          if (enable) begin
            r_state    <= ST_RUN;
            r_pkt      <= pkt_beats;
            r_cnt      <= '0;
            r_half_vld <= 1'b0;
          end
        end
        ST_RUN: begin
          if (sum_valid) begin
            if (!r_half_vld) begin
              r_half     <= w_sample;
              r_half_vld <= 1'b1;
            end else begin
              r_half_vld <= 1'b0;
              if (w_can_push) r_cnt <= w_last ? '0 : w_cnt_nxt;
            end
          end
          if (!enable) r_state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if ((!r_half_vld && r_cnt == '0) || w_can_push) begin
            r_half_vld <= 1'b0;
            r_cnt      <= '0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_drop)            r_ovf <= 1'b1;
      else if (clr_overflow) r_ovf <= 1'b0;
    end
  end

  xbf_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_wdata (w_entry),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = w_empty ? '0 : w_rdata[ENTRY_W-1 -: AXIS_W];
  assign m_axis_tkeep  = w_empty ? '0 : w_rdata[KEEP_W:1];
  assign m_axis_tlast  = !w_empty && w_rdata[0];
  assign overflow      = r_ovf;
endmodule

`default_nettype wire
